// File: rtl/nco_sincos_pkg.sv
// Shared types and constants for the sin/cos NCO: quadrant code, quarter-wave
// table generator, and the dither LFSR polynomial/seed.
package nco_sincos_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    localparam int unsigned LFSR_W = 16;
    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    localparam real HALF_PI = 1.5707963267948966;

    // Half-bin-centred quarter-wave sample, evaluated at elaboration.
    function automatic int lut_val(int k, int lut_aw, int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = HALF_PI * real'(2 * k + 1) / real'(1 << (lut_aw + 1));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_sincos_if.sv
// Control and sample-stream bundle of the sin/cos NCO.
interface nco_sincos_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16
) ();
    logic                    en;
    logic                    cfg_valid;
    logic [ACC_W-1:0]        fcw_in;
    logic [ACC_W-1:0]        poff_in;
    logic                    phase_sync;
    logic                    m_tready;
    logic                    m_tvalid;
    logic signed [OUT_W-1:0] sin;
    logic signed [OUT_W-1:0] cos;

    // NCO side drives the sample stream
    modport master (
        input  en, cfg_valid, fcw_in, poff_in, phase_sync, m_tready,
        output m_tvalid, sin, cos
    );

    // Controller / consumer side
    modport slave (
        output en, cfg_valid, fcw_in, poff_in, phase_sync, m_tready,
        input  m_tvalid, sin, cos
    );
endinterface

// File: rtl/nco_sincos_qrom.sv
// Dual-read registered quarter-wave sine ROM: returns T[addr] and T[~addr].
module nco_sincos_qrom
    import nco_sincos_pkg::*;
#(
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [LUT_AW-1:0]       addr,
    output logic signed [OUT_W-1:0] t_a,
    output logic signed [OUT_W-1:0] t_na
);
    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic signed [OUT_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_rom
        assign rom[k] = OUT_W'(lut_val(k, int'(LUT_AW), int'(OUT_W)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_a  <= '0;
            t_na <= '0;
        end else if (en) begin
            t_a  <= rom[addr];
            t_na <= rom[~addr];
        end
    end

endmodule

// File: rtl/nco_sincos.sv
// Phase-accumulator NCO producing sin/cos on a valid/ready stream (3-stage pipe).
// Define NCO_SINCOS_DITHER_EN to add LFSR phase dither below the truncation point.
module nco_sincos
    import nco_sincos_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned OUT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    nco_sincos_if.master bus
);
    localparam int unsigned PH_W   = LUT_AW + 2;
    localparam int unsigned DISC_W = ACC_W - PH_W;

    logic                    adv_c;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        fcw;
    logic [ACC_W-1:0]        poff;
    logic [PH_W-1:0]         ph_c;
    quad_t                   q0;
    quad_t                   q1;
    logic [LUT_AW-1:0]       a0;
    logic                    v0;
    logic                    v1;
    logic                    v2;
    logic signed [OUT_W-1:0] t_a;
    logic signed [OUT_W-1:0] t_na;
    logic signed [OUT_W-1:0] sin_q;
    logic signed [OUT_W-1:0] cos_q;
    logic signed [OUT_W-1:0] sin_n;
    logic signed [OUT_W-1:0] cos_n;

    assign adv_c = !v2 || bus.m_tready;

`ifdef NCO_SINCOS_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (adv_c) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
        end
    end

    // LFSR MSB lands on the highest discarded phase bit
    assign ph_c = PH_W'((acc + poff
                  + ACC_W'(({{ACC_W{1'b0}}, lfsr} << DISC_W) >> LFSR_W)) >> DISC_W);
`else
    assign ph_c = PH_W'((acc + poff) >> DISC_W);
`endif

    // Config loads independently of stream backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw  <= '0;
            poff <= '0;
        end else if (bus.cfg_valid) begin
            fcw  <= bus.fcw_in;
            poff <= bus.poff_in;
        end
    end

    // Accumulator and S0 phase split
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            q0  <= QUAD_0;
            a0  <= '0;
            v0  <= 1'b0;
        end else if (adv_c) begin
            if (bus.phase_sync) begin
                acc <= '0;
            end else if (bus.en) begin
                acc <= acc + fcw;
            end
            q0 <= quad_t'(ph_c[PH_W-1 -: 2]);
            a0 <= ph_c[LUT_AW-1:0];
            v0 <= bus.en;
        end
    end

    nco_sincos_qrom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_qrom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv_c),
        .addr  (a0),
        .t_a   (t_a),
        .t_na  (t_na)
    );

    // S1 side-band alongside the ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= QUAD_0;
            v1 <= 1'b0;
        end else if (adv_c) begin
            q1 <= q0;
            v1 <= v0;
        end
    end

    // Quadrant sign/select
    always_comb begin
        sin_n = t_a;
        cos_n = t_na;
        unique case (q1)
            QUAD_0: begin
                sin_n = t_a;
                cos_n = t_na;
            end
            QUAD_1: begin
                sin_n = t_na;
                cos_n = -t_a;
            end
            QUAD_2: begin
                sin_n = -t_a;
                cos_n = -t_na;
            end
            QUAD_3: begin
                sin_n = -t_na;
                cos_n = t_a;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_q <= '0;
            cos_q <= '0;
            v2    <= 1'b0;
        end else if (adv_c) begin
            sin_q <= sin_n;
            cos_q <= cos_n;
            v2    <= v1;
        end
    end

    assign bus.m_tvalid = v2;
    assign bus.sin      = sin_q;
    assign bus.cos      = cos_q;

endmodule

// File: doc/nco_sincos.md
Name: nco_sincos

Overview:
Parametrised numerically-controlled oscillator that produces sine and cosine samples.
- Replaces the vendor-CORDIC sin/cos wrapper with native RTL.
- Adds an internal phase accumulator, runtime frequency and phase-offset programming, phase sync, and output backpressure.
- Feeds the FIR test-signal path and mixers; sin/cos are two's-complement samples on a valid/ready stream.

Parameters:
ACC_W, 32, phase accumulator width (modulo 2^ACC_W = one full cycle)
LUT_AW, 10, quarter-wave table address bits (phase resolution LUT_AW+2 bits)
OUT_W, 16, sample width, signed, amplitude A = 2^(OUT_W-1)-1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  generate one sample per advancing cycle
cfg_valid  in  1  load fcw_in/poff_in this cycle
fcw_in  in  ACC_W  frequency control word (phase increment, unsigned, wraps)
poff_in  in  ACC_W  phase offset added after accumulator
phase_sync  in  1  clear accumulator to 0
m_tready  in  1  downstream ready
m_tvalid  out  1  sin/cos valid
sin  out  OUT_W  sine sample, signed
cos  out  OUT_W  cosine sample, signed

Behaviour:
- Reset (async assert, sync release): acc, fcw, poff = 0; all pipeline valid bits = 0; m_tvalid = 0; sin = cos = 0.
- adv = !m_tvalid || m_tready. When adv is low, every register except cfg holds and sin/cos are stable.
- cfg_valid: fcw/poff register at the next edge regardless of adv. The first accumulator update using the new fcw is the following advancing cycle.
- Accumulator update, when adv:
  - phase_sync: acc <= 0 (priority over increment).
  - else if en: acc <= acc + fcw, mod 2^ACC_W.
- Pipeline stages, all gated by adv:
  - S0: p = acc + poff (mod 2^ACC_W); take the top LUT_AW+2 bits; q = top 2 bits, a = the next LUT_AW bits; v0 = en.
  - S1: ROM reads T[a] and T[~a], registered (dual read).
  - S2: sign/select, registered onto sin/cos; m_tvalid = v2.
  - Latency: an acc value A reaches the output 3 advancing cycles after S0 samples it. Gaps from en=0 propagate as m_tvalid=0 bubbles.
- Table contents: T[k] = round(A * sin(pi/2 * (2k+1) / 2^(LUT_AW+1))), k = 0 .. 2^LUT_AW-1. The half-bin offset makes the mirror index exactly ~a.
- Quadrant mapping (sin, cos):
  - q=0: (+T[a], +T[~a])
  - q=1: (+T[~a], -T[a])
  - q=2: (-T[a], -T[~a])
  - q=3: (-T[~a], +T[a])
  - Negation cannot overflow because |T| <= A.
- Boundary conditions:
  - fcw = 0 gives a constant output.
  - fcw = 2^ACC_W-1 gives a negative frequency (the accumulator decrements).
  - phase_sync while stalled is applied at the next advancing edge.
  - Samples already in flight keep their old phase; there is no flush.

Optional Feature:
Macro NCO_SINCOS_DITHER_EN.
- Defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset, steps on adv) supplies random bits aligned to the discarded LSBs below the truncation point. These are added to p before truncation, which spreads spurs.
- Undefined: plain truncation, and outputs are bit-exact to the mapping above.

Decomposition:
- Package nco_sincos_pkg:
  - quadrant typedef (2 bits);
  - constant function computing T[k] from LUT_AW/OUT_W via real math at elaboration;
  - LFSR polynomial and seed constants.
- Sub-module nco_sincos_qrom: dual-read registered quarter-wave ROM, parameters LUT_AW and OUT_W.

Test Plan:
All scenarios use defaults, dither off, m_tready=1 unless stated.
1. Reset, cfg fcw=0x40000000, poff=0, en=1 -> from the 4th cycle after en, sin = 25, 32767, -25, -32767 repeating; cos = 32767, -25, -32767, 25 repeating.
2. Scenario 1, then hold m_tready=0 for 5 cycles mid-stream -> m_tvalid stays 1 and sin/cos are frozen; on release the sequence continues with no sample lost or duplicated.
3. fcw=0xFFFFFFFF, phase_sync pulse -> after sync the first sample is sin=25, cos=32767; the next is sin=-25, cos=32767 (q=3, a=1023).
4. fcw=0, poff=0x80000000 -> constant sin=-25, cos=-32767.
5. en toggled 1,0,1 -> m_tvalid shows a one-cycle bubble 3 cycles later; acc advances only twice.
6. Assert rst_n low mid-stream, asynchronously between edges -> m_tvalid/sin/cos go to 0 immediately; after release and a repeat cfg the outputs match scenario 1 exactly.
